// File: rtl/segway_telem_pkg.sv
// Shared definitions for the Segway-side telemetry return link.
// Holds the frame FSM state type, frame geometry, the default header byte,
// bit positions of the status byte and the frame checksum helpers.
package segway_telem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT,
      DONE
   } frame_state_t;

   localparam int         FRAME_LEN   = 7;
   localparam logic [7:0] HDR_DEFAULT = 8'hA5;

   // Bit positions inside status byte B1 (bit 0 is always zero)
   localparam int ST_PWR_UP     = 7;
   localparam int ST_EN_STEER   = 6;
   localparam int ST_RIDER_OFF  = 5;
   localparam int ST_TOO_FAST   = 4;
   localparam int ST_BATT_LOW   = 3;
   localparam int ST_OVR_I_LFT  = 2;
   localparam int ST_OVR_I_RGHT = 1;

   // Turns a running mod-256 sum into the closing byte so the frame sums to zero.
   function automatic logic [7:0] cksum_close(input logic [7:0] sum);
      return 8'(~sum + 8'd1);
   endfunction

   // Checksum of a complete payload B0..B5, B0 in the top byte.
   function automatic logic [7:0] frame_checksum(input logic [47:0] payload);
      logic [7:0] sum;
      sum = 8'h00;
      for (int i = 0; i < FRAME_LEN - 1; i++)
         sum = sum + payload[47-8*i -: 8];
      return cksum_close(sum);
   endfunction

endpackage

// File: rtl/UART_tx.sv
// 8N1 UART transmitter, LSB first, idle high.
// Ports: clk, rst_n (async active-low), trmt (one-cycle start strobe),
//        tx_data (byte to send), TX (serial out), tx_done (one-cycle pulse
//        at the end of the stop bit).
module UART_tx #(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       TX,
   output logic       tx_done
);

   localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   logic [9:0]    shift_reg;
   logic [BW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic          shifting;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '1;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shifting  <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (trmt) begin
            shift_reg <= {1'b1, tx_data, 1'b0};
            baud_cnt  <= BAUD_LAST;
            bit_cnt   <= '0;
            shifting  <= 1'b1;
         end else if (shifting) begin
            if (baud_cnt == '0) begin
               baud_cnt  <= BAUD_LAST;
               // Shifting in ones leaves the line idle-high after the stop bit
               shift_reg <= {1'b1, shift_reg[9:1]};
               if (bit_cnt == 4'd9) begin
                  shifting <= 1'b0;
                  tx_done  <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 4'd1;
               end
            end else begin
               baud_cnt <= baud_cnt - BW'(1);
            end
         end
      end
   end

   assign TX = shift_reg[0];

endmodule

// File: rtl/telemetry_tx.sv
// Segway-to-BLE status reporter. Sends a 7-byte frame (header, status,
// battery, left speed, checksum) periodically while en is high and on each
// req pulse. Inputs are snapshotted at frame start.
// Ports: clk, rst_n (async active-low), en, req, status flags (pwr_up,
//        en_steer, rider_off, too_fast, batt_low, OVR_I_lft, OVR_I_rght),
//        batt[11:0], lft_spd[11:0], TX (serial out), busy, frame_done.
//
// state | meaning
// IDLE  | waiting for pending; on pending capture snapshot and start frame
// LOAD  | present byte[index] to UART_tx with trmt, accumulate checksum
// WAIT  | wait for tx_done; advance index or finish
// DONE  | frame_done pulse, back to IDLE
import segway_telem_pkg::*;

module telemetry_tx #(
   parameter int         PERIOD   = 1250000,
   parameter logic [7:0] HDR      = HDR_DEFAULT,
   parameter int         BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        req,
   input  logic        pwr_up,
   input  logic        en_steer,
   input  logic        rider_off,
   input  logic        too_fast,
   input  logic        batt_low,
   input  logic        OVR_I_lft,
   input  logic        OVR_I_rght,
   input  logic [11:0] batt,
   input  logic [11:0] lft_spd,
   output logic        TX,
   output logic        busy,
   output logic        frame_done
);

   localparam int              CNT_W    = $clog2(PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
   localparam logic [2:0]      IDX_LAST = 3'(FRAME_LEN - 1);

   frame_state_t     state;
   logic [CNT_W-1:0] period_cnt;
   logic             tick;
   logic             pending;
   logic [2:0]       byte_idx;
   logic [7:0]       cksum;
   logic [7:0]       snap_status;
   logic [11:0]      snap_batt;
   logic [11:0]      snap_spd;
   logic [7:0]       status_in;
   logic [7:0]       cur_byte;
   logic             trmt;
   logic             tx_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         period_cnt <= '0;
      else if (!en || period_cnt == CNT_LAST)
         period_cnt <= '0;
      else
         period_cnt <= period_cnt + CNT_W'(1);
   end

   assign tick = en && (period_cnt == CNT_LAST);

   always_comb begin
      status_in                = 8'h00;
      status_in[ST_PWR_UP]     = pwr_up;
      status_in[ST_EN_STEER]   = en_steer;
      status_in[ST_RIDER_OFF]  = rider_off;
      status_in[ST_TOO_FAST]   = too_fast;
      status_in[ST_BATT_LOW]   = batt_low;
      status_in[ST_OVR_I_LFT]  = OVR_I_lft;
      status_in[ST_OVR_I_RGHT] = OVR_I_rght;
   end

   always_comb begin
      cur_byte = HDR;
      case (byte_idx)
         3'd0:    cur_byte = HDR;
         3'd1:    cur_byte = snap_status;
         3'd2:    cur_byte = {4'h0, snap_batt[11:8]};
         3'd3:    cur_byte = snap_batt[7:0];
         3'd4:    cur_byte = {{4{snap_spd[11]}}, snap_spd[11:8]};
         3'd5:    cur_byte = snap_spd[7:0];
         default: cur_byte = cksum_close(cksum);
      endcase
   end

   assign trmt = (state == LOAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pending     <= 1'b0;
         byte_idx    <= '0;
         cksum       <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         snap_status <= '0;
         snap_batt   <= '0;
         snap_spd    <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (pending) begin
                  snap_status <= status_in;
                  snap_batt   <= batt;
                  snap_spd    <= lft_spd;
                  byte_idx    <= '0;
                  cksum       <= '0;
                  busy        <= 1'b1;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               if (byte_idx != IDX_LAST)
                  cksum <= cksum + cur_byte;
               state <= WAIT;
            end
            WAIT: begin
               if (tx_done) begin
                  if (byte_idx == IDX_LAST) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     state      <= DONE;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     state    <= LOAD;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase

         // A trigger coinciding with the capture cycle wins: it asks for a new frame
         if (req || tick)
            pending <= 1'b1;
         else if (state == IDLE && pending)
            pending <= 1'b0;
      end
   end

   UART_tx #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .trmt    (trmt),
      .tx_data (cur_byte),
      .TX      (TX),
      .tx_done (tx_done)
   );

endmodule

// File: tb/tb_telemetry_tx.sv
module tb_telemetry_tx;
   import segway_telem_pkg::*;

   localparam int PERIOD = 1000;
   localparam int BAUD   = 8;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        req;
   logic        pwr_up;
   logic        en_steer;
   logic        rider_off;
   logic        too_fast;
   logic        batt_low;
   logic        OVR_I_lft;
   logic        OVR_I_rght;
   logic [11:0] batt;
   logic [11:0] lft_spd;
   logic        TX;
   logic        busy;
   logic        frame_done;

   int chk = 0;
   int errs = 0;
   int fd_cnt = 0;
   int rst_evt = 0;
   int cyc = 0;
   logic [7:0] exp_q[$];

   telemetry_tx #(.PERIOD(PERIOD), .HDR(8'hA5), .BAUD_DIV(BAUD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .req        (req),
      .pwr_up     (pwr_up),
      .en_steer   (en_steer),
      .rider_off  (rider_off),
      .too_fast   (too_fast),
      .batt_low   (batt_low),
      .OVR_I_lft  (OVR_I_lft),
      .OVR_I_rght (OVR_I_rght),
      .batt       (batt),
      .lft_spd    (lft_spd),
      .TX         (TX),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge rst_n) rst_evt = rst_evt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      chk++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [55:0] make_frame(input logic [7:0] st, input logic [11:0] b,
                                              input logic [11:0] s);
      logic [47:0] p;
      p = {8'hA5, st, 4'h0, b[11:8], b[7:0], {4{s[11]}}, s[11:8], s[7:0]};
      return {p, frame_checksum(p)};
   endfunction

   task automatic push7(input logic [55:0] f);
      for (int i = 0; i < 7; i++) exp_q.push_back(f[55-8*i -: 8]);
   endtask

   task automatic pulse_req();
      @(negedge clk) req = 1'b1;
      @(negedge clk) req = 1'b0;
   endtask

   task automatic wait_fd(input int target, input int bound);
      int k;
      k = 0;
      while (fd_cnt < target && k < bound) begin
         @(posedge clk); #2;
         k++;
      end
      check("frame_done_count", fd_cnt, target);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(posedge clk);
      @(negedge clk);
   endtask

   // frame_done pulse counter and width check
   initial begin : fd_mon
      logic fd_prev;
      fd_prev = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (frame_done === 1'b1) begin
            fd_cnt++;
            check("frame_done_width", fd_prev, 1'b0);
         end
         fd_prev = (frame_done === 1'b1);
      end
   end

   // Serial receiver: decodes TX and compares each byte against the scoreboard
   initial begin : rx_mon
      logic [7:0] b;
      logic [7:0] fsum;
      logic       ok;
      int         pos;
      int         r0;
      pos  = 0;
      fsum = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (rst_n !== 1'b1) begin
            pos  = 0;
            fsum = 8'h00;
         end else if (TX === 1'b0) begin
            ok = 1'b1;
            r0 = rst_evt;
            repeat (BAUD / 2) @(posedge clk);
            #1;
            if (TX !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (BAUD) @(posedge clk);
               #1;
               b[i] = TX;
            end
            repeat (BAUD) @(posedge clk);
            #1;
            if (TX !== 1'b1) ok = 1'b0;
            if (rst_evt != r0 || !ok) begin
               pos  = 0;
               fsum = 8'h00;
            end else begin
               chk++;
               assert (exp_q.size() != 0) else begin
                  errs++;
                  $error("FAIL rx_unexpected: observed byte %0h expected none", b);
               end
               if (exp_q.size() != 0) check("rx_byte", b, exp_q.pop_front());
               fsum = fsum + b;
               pos++;
               if (pos == 7) begin
                  check("frame_sum", fsum, 8'h00);
                  pos  = 0;
                  fsum = 8'h00;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int n, f1, f2, c0, fd0, lows, busy_hi, k;
      rst_n = 1'b0; en = 1'b0; req = 1'b0;
      pwr_up = 0; en_steer = 0; rider_off = 0; too_fast = 0; batt_low = 0;
      OVR_I_lft = 0; OVR_I_rght = 0; batt = 12'h000; lft_spd = 12'h000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_TX", TX, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      check("idle_TX", TX, 1'b1);
      check("idle_busy", busy, 1'b0);

      // Frame 1: basic request
      @(negedge clk);
      pwr_up = 1; en_steer = 1; batt = 12'hB3C; lft_spd = 12'h0F0;
      push7(56'hA5_C0_0B_3C_00_F0_64);
      fd0 = fd_cnt;
      req = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         req = 1'b0;
         n++;
         if (n == 2) check("busy_at_capture", busy, 1'b1);
      end while (TX !== 1'b0 && n < 20);
      check("req_latency", n, 3);
      wait_fd(fd0 + 1, 2000);
      @(posedge clk); #2;
      check("fd_cleared", frame_done, 1'b0);
      check("busy_after_frame", busy, 1'b0);
      check("t1_all_rx", exp_q.size(), 0);

      // Frame 2: negative speed, over-current flags
      @(negedge clk);
      pwr_up = 0; en_steer = 0; OVR_I_lft = 1; OVR_I_rght = 1;
      batt = 12'h000; lft_spd = 12'h800;
      push7(56'hA5_06_00_00_F8_00_5D);
      fd0 = fd_cnt;
      pulse_req();
      wait_fd(fd0 + 1, 2000);
      check("t2_all_rx", exp_q.size(), 0);

      // Snapshot frozen during the frame
      @(negedge clk);
      OVR_I_lft = 0; OVR_I_rght = 0; lft_spd = 12'h000; batt = 12'h100;
      push7(make_frame(8'h00, 12'h100, 12'h000));
      fd0 = fd_cnt;
      pulse_req();
      k = 0;
      while (busy !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
      check("snap_busy", busy, 1'b1);
      repeat (100) @(posedge clk);
      @(negedge clk) batt = 12'hFFF;
      wait_fd(fd0 + 1, 2000);
      push7(make_frame(8'h00, 12'hFFF, 12'h000));
      pulse_req();
      wait_fd(fd0 + 2, 2000);
      check("snap_all_rx", exp_q.size(), 0);

      // Periodic frames, then several triggers during one frame
      @(negedge clk);
      too_fast = 1; batt_low = 1; batt = 12'h7A5; lft_spd = 12'h123;
      push7(make_frame(8'h18, 12'h7A5, 12'h123));
      push7(make_frame(8'h18, 12'h7A5, 12'h123));
      fd0 = fd_cnt;
      en = 1'b1;
      c0 = cyc;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (TX !== 1'b0 && n < 3000);
      check("period_first", n, PERIOD + 2);
      f1 = cyc;
      wait_fd(fd0 + 1, 3000);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (TX !== 1'b0 && n < 3000);
      f2 = cyc;
      check("period_interval", f2 - f1, PERIOD);
      wait_fd(fd0 + 2, 3000);
      push7(make_frame(8'h18, 12'h7A5, 12'h123));
      push7(make_frame(8'h18, 12'h7A5, 12'h123));
      wait_until(c0 + 2700); req = 1'b1; @(negedge clk) req = 1'b0;
      wait_until(c0 + 2750); req = 1'b1; @(negedge clk) req = 1'b0;
      wait_until(c0 + 2800); req = 1'b1; @(negedge clk) req = 1'b0;
      wait_until(c0 + 2850); req = 1'b1; @(negedge clk) req = 1'b0;
      wait_until(c0 + 3100); en = 1'b0;
      wait_fd(fd0 + 4, 3000);
      repeat (1500) @(posedge clk);
      #2;
      check("one_extra_frame", fd_cnt, fd0 + 4);
      check("multi_busy_low", busy, 1'b0);
      check("multi_all_rx", exp_q.size(), 0);

      // Reset in the middle of byte B3
      @(negedge clk);
      too_fast = 0; batt_low = 0; rider_off = 1; batt = 12'h555; lft_spd = 12'hAAA;
      push7(make_frame(8'h20, 12'h555, 12'hAAA));
      fd0 = fd_cnt;
      pulse_req();
      k = 0;
      while (exp_q.size() > 4 && k < 2000) begin @(posedge clk); #1; k++; end
      check("rst_pre_bytes", exp_q.size(), 4);
      repeat (20) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      check("midrst_TX", TX, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_frame_done", frame_done, 1'b0);
      repeat (20) @(posedge clk);
      exp_q.delete();
      @(negedge clk) rst_n = 1'b1;
      lows = 0;
      busy_hi = 0;
      repeat (10000) begin
         @(posedge clk); #1;
         if (TX !== 1'b1) lows++;
         if (busy !== 1'b0) busy_hi++;
      end
      check("post_rst_TX_quiet", lows, 0);
      check("post_rst_busy_quiet", busy_hi, 0);
      check("post_rst_no_fd", fd_cnt, fd0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", chk, errs);
      $finish;
   end

endmodule
